// File: rtl/fifo_syn.sv
// fifo_syn: single-clock synchronous FIFO with registered read data, empty/full flags and occupancy count
module fifo_syn #(
  parameter int width = 8,
  parameter int depth = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fifo_wrEn,
  input  logic                     fifo_rdEn,
  input  logic [width-1:0]         fifo_wrData,
  output logic [width-1:0]         fifo_rdData,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  output logic [$clog2(depth):0]   data_count
);
  localparam int aw = $clog2(depth);
  localparam logic [aw:0] full_cnt = (aw+1)'(depth);
  logic [width-1:0] mem_q [depth];
  logic [aw-1:0]    wr_ptr_q, rd_ptr_q;
  logic [aw:0]      count_q, count_d;
  logic [width-1:0] rd_data_q;
  logic             wr_ok, rd_ok;
  assign fifo_empty  = count_q == '0;
  assign fifo_full   = count_q == full_cnt;
  assign data_count  = count_q;
  assign fifo_rdData = rd_data_q;
  assign rd_ok = fifo_rdEn && !fifo_empty;
  // a read on the same edge frees the slot, so a full FIFO still accepts the write
  assign wr_ok = fifo_wrEn && (!fifo_full || rd_ok);
  always_comb begin
    count_d = count_q;
    count_d = (wr_ok && !rd_ok) ? count_q + (aw+1)'(1) :
              (rd_ok && !wr_ok) ? count_q - (aw+1)'(1) : count_q;
  end
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= fifo_wrData;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      count_q <= count_d;
      if (wr_ok) wr_ptr_q <= wr_ptr_q + aw'(1);
      if (rd_ok) begin
        rd_ptr_q  <= rd_ptr_q + aw'(1);
        rd_data_q <= mem_q[rd_ptr_q];
      end
    end
  end
endmodule

// File: tb/tb_fifo_syn.sv
// tb_fifo_syn: directed and random checks of fifo_syn against a queue-based reference model
module tb_fifo_syn;
  localparam int W = 8;
  localparam int D = 8;
  logic         clk = 0;
  logic         reset = 1;
  logic         fifo_wrEn = 0;
  logic         fifo_rdEn = 0;
  logic [W-1:0] fifo_wrData = '0;
  logic [W-1:0] fifo_rdData;
  logic         fifo_empty, fifo_full;
  logic [3:0]   data_count;
  logic [W-1:0] q [$];
  logic [W-1:0] exp_rd = '0;
  int n_assert = 0;
  int n_fail = 0;

  fifo_syn #(.width(W), .depth(D)) dut (
    .clk(clk), .reset(reset), .fifo_wrEn(fifo_wrEn), .fifo_rdEn(fifo_rdEn),
    .fifo_wrData(fifo_wrData), .fifo_rdData(fifo_rdData), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .data_count(data_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag);
    logic [3:0] exp_cnt;
    logic       exp_empty, exp_full;
    exp_cnt   = 4'(q.size());
    exp_empty = q.size() == 0;
    exp_full  = q.size() == D;
    n_assert += 4;
    assert (fifo_rdData === exp_rd) else begin
      n_fail++; $error("FAIL %s rdData got %h expected %h", tag, fifo_rdData, exp_rd);
    end
    assert (data_count === exp_cnt) else begin
      n_fail++; $error("FAIL %s data_count got %0d expected %0d", tag, data_count, exp_cnt);
    end
    assert (fifo_empty === exp_empty) else begin
      n_fail++; $error("FAIL %s empty got %b expected %b", tag, fifo_empty, exp_empty);
    end
    assert (fifo_full === exp_full) else begin
      n_fail++; $error("FAIL %s full got %b expected %b", tag, fifo_full, exp_full);
    end
  endtask

  // one clock: drive, apply the accept rules to the model, check 1 time unit after the edge
  task automatic step(input logic w, input logic r, input logic [W-1:0] d, input string tag);
    bit rd_ok, wr_ok;
    fifo_wrEn = w; fifo_rdEn = r; fifo_wrData = d;
    @(posedge clk);
    rd_ok = r && q.size() != 0;
    wr_ok = w && (q.size() != D || rd_ok);
    if (rd_ok) exp_rd = q.pop_front();
    if (wr_ok) q.push_back(d);
    #1;
    fifo_wrEn = 0; fifo_rdEn = 0;
    chk(tag);
  endtask

  initial begin
    @(posedge clk); #1;
    chk("reset");
    @(negedge clk) reset = 0;
    step(1, 0, 8'h01, "single_wr");
    step(0, 1, 8'h00, "single_rd");
    for (int i = 1; i <= 8; i++) step(1, 0, W'(i), "fill");
    step(1, 0, 8'h09, "overflow");
    for (int i = 0; i < 8; i++) step(0, 1, 8'h00, "drain");
    step(0, 1, 8'h00, "rd_empty");
    for (int i = 0; i < 3; i++) step(1, 0, W'(8'h40 + i), "pre3");
    step(1, 1, 8'h50, "simul_3");
    for (int i = 0; i < 5; i++) step(1, 0, W'(8'h60 + i), "to_full");
    step(1, 1, 8'h70, "simul_full");
    for (int i = 0; i < 8; i++) step(0, 1, 8'h00, "drain2");
    step(1, 1, 8'h80, "simul_empty");
    step(0, 1, 8'h00, "rd_80");
    for (int i = 0; i < 12; i++) step(1, i >= 3, W'(8'h0A + i), "wrap");
    for (int i = 0; i < 3; i++) step(0, 1, 8'h00, "wrap_drain");
    for (int i = 0; i < 5; i++) step(1, 0, W'(8'h20 + i), "pre_rst");
    @(negedge clk);
    #2 reset = 1;
    q.delete(); exp_rd = '0;
    #1 chk("async_rst");
    @(negedge clk) reset = 0;
    step(1, 0, 8'h33, "post_rst_wr");
    step(0, 1, 8'h00, "post_rst_rd");
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, W'($urandom), "random");
    while (q.size() != 0) step(0, 1, 8'h00, "final_drain");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_syn.md
Name: fifo_syn

Overview:
Single-clock synchronous FIFO with parameterizable data width and depth. It buffers data words between a producer and a consumer in the same clock domain. It provides registered read data, empty/full status flags, and a live occupancy count. It is a general-purpose leaf block for datapath buffering.

Parameters:
- width, 8, data word width in bits (>=1)
- depth, 8, number of storage entries; must be a power of two and >=2

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high reset
- fifo_wrEn  input  1  write request; sampled on rising clk
- fifo_rdEn  input  1  read request; sampled on rising clk
- fifo_wrData  input  width  data to write
- fifo_rdData  output  width  registered read data
- fifo_empty  output  1  high when occupancy == 0
- fifo_full  output  1  high when occupancy == depth
- data_count  output  $clog2(depth)+1  current occupancy, range 0..depth

Behaviour:
- Storage: depth x width array, not reset. Write pointer and read pointer are each $clog2(depth) bits and wrap naturally from depth-1 to 0.
- Reset (asynchronous, active-high, takes effect immediately regardless of clk):
  - pointers = 0, data_count = 0, fifo_rdData = 0
  - fifo_empty = 1, fifo_full = 0
  - These values hold while reset is high.
- Flags are combinational decodes of data_count: fifo_empty = (data_count==0), fifo_full = (data_count==depth).
- Write accept: wr_ok = fifo_wrEn && (!fifo_full || rd_ok).
  - On accept, mem[wr_ptr] <= fifo_wrData and wr_ptr increments.
- Read accept: rd_ok = fifo_rdEn && !fifo_empty.
  - On accept, fifo_rdData <= mem[rd_ptr] and rd_ptr increments.
  - Latency: data is valid on fifo_rdData after the same rising edge that samples rdEn; i.e. one clock after rdEn is asserted.
- fifo_rdData holds its last value when no read is accepted, including a read while empty.
- No fall-through: a write into an empty FIFO is not readable in the same cycle; read while empty is ignored even if a simultaneous write is accepted.
- data_count update each edge:
  - +1 on wr_ok only
  - -1 on rd_ok only
  - unchanged when both or neither are accepted
- Boundary conditions:
  - write while full without a read: ignored; no state change
  - write + read while full: both accepted; count stays at depth
  - write + read while empty: write only; count becomes 1
  - read while empty: ignored; no state change
- Held enables: a level-held fifo_rdEn/fifo_wrEn performs one transfer per clock edge, subject to the accept rules.
- Reset asserted mid-operation discards all contents; the next read after reset returns data written after reset.

Decomposition:
- No shared package needed.
- The pointer-width constant ($clog2(depth)) is a localparam inside the module.
- Single module; no sub-modules. Storage is an inferred register array.

Test Plan:
- Reset: assert reset for 1 cycle -> fifo_empty=1, fifo_full=0, data_count=0, fifo_rdData=0.
- Single write/read: write 0x01, then assert rdEn 1 cycle -> data_count goes 1 then 0; fifo_rdData=0x01 after the read edge; fifo_empty=1 again.
- Fill/overflow: write 0x01..0x08 -> fifo_full=1, data_count=8; 9th write 0x09 ignored with count still 8. Drain 8 reads -> 0x01..0x08 in order. Extra read while empty -> fifo_rdData stays 0x08, count 0.
- Simultaneous: at data_count=3, assert wrEn and rdEn together 1 cycle -> count stays 3, oldest word read. Same at full (count 8) -> count stays 8, fifo_full stays 1. At empty -> count becomes 1, fifo_rdData unchanged.
- Wrap-around: interleave 12 writes (0x0A..0x15) with reads keeping count <=5 -> all 12 words read back in order across the pointer wrap.
- Async reset mid-run: at count=5, assert reset between clock edges -> data_count=0 and fifo_empty=1 immediately; then write 0x33 and read -> 0x33.
